// File: rtl/if_stage__pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
// Imported by if_stage_ and if_id_reg_.
package if_stage__pkg;

   localparam logic [1:0]  PCSRC_SEQ = 2'b00;
   localparam logic [1:0]  PCSRC_BR  = 2'b01;
   localparam logic [1:0]  PCSRC_J   = 2'b10;

   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      StRun  = 2'b00,
      StWait = 2'b01,
      StHalt = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/if_stage__if_id_reg.sv
// IF/ID pipeline register: PC4D, InstructionD and validD.
// Priority is hold > bubble > load; PC4D is untouched by a bubble.
module if_id_reg_ #(
   parameter logic [31:0] NOP_WORD = if_stage__pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_hold,
   input  logic        i_bubble,
   input  logic        i_load,
   input  logic [31:0] i_pc4,
   input  logic [31:0] i_instr,
   output logic [31:0] o_pc4,
   output logic [31:0] o_instr,
   output logic        o_valid
);

   logic [31:0] r_pc4;
   logic [31:0] r_instr;
   logic        r_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc4   <= 32'h0;
         r_instr <= NOP_WORD;
         r_valid <= 1'b0;
      end else if (!i_hold) begin
         if (i_bubble) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
         end else if (i_load) begin
            r_pc4   <= i_pc4;
            r_instr <= i_instr;
            r_valid <= 1'b1;
         end
      end
   end

   assign o_pc4   = r_pc4;
   assign o_instr = r_instr;
   assign o_valid = r_valid;

endmodule

// File: rtl/if_stage_.sv
// Instruction-fetch stage: word-addressed PC, next-PC select, RUN/WAIT/HALT control,
// and the IF/ID register feeding decode.
module if_stage_ #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD  = if_stage__pkg::NOP_WORD,
   parameter logic [31:0] HALT_WORD = if_stage__pkg::HALT_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  PCSourceD,
   input  logic [31:0] PC_B,
   input  logic [31:0] PC_J,
   input  logic        isLWHazard,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   output logic [31:0] imem_addr,
   output logic [31:0] PC4D,
   output logic [31:0] InstructionD,
   output logic        validD,
   output logic        halted,
   output logic [31:0] fetch_count
);

   import if_stage__pkg::*;

   fetch_state_e r_state;
   fetch_state_e w_state_next;
   logic [31:0]  r_pc;
   logic [31:0]  r_fetch_count;
   logic         r_halted;

   logic [31:0]  w_pc_next;
   logic [31:0]  w_pc_inc;
   logic [31:0]  w_target;
   logic         w_redirect;
   logic         w_hold;
   logic         w_bubble;
   logic         w_load;

   assign w_pc_inc   = r_pc + 32'd1;
   assign w_redirect = (PCSourceD == PCSRC_BR) || (PCSourceD == PCSRC_J);
   assign w_target   = (PCSourceD == PCSRC_BR) ? PC_B : PC_J;

   // WAIT differs from RUN only in bookkeeping: a ready word is consumed the same cycle.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_hold       = 1'b0;
      w_bubble     = 1'b0;
      w_load       = 1'b0;
      if (r_state == StHalt) begin
         w_hold = 1'b1;
      end else if (isLWHazard) begin
         w_hold = 1'b1;
      end else if (w_redirect) begin
         w_pc_next    = w_target;
         w_bubble     = 1'b1;
         w_state_next = StRun;
      end else if (!imem_ready) begin
         w_bubble     = 1'b1;
         w_state_next = StWait;
      end else if (imem_data == HALT_WORD) begin
         w_bubble     = 1'b1;
         w_state_next = StHalt;
      end else begin
         w_pc_next    = w_pc_inc;
         w_load       = 1'b1;
         w_state_next = StRun;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= StRun;
         r_pc          <= RESET_PC;
         r_halted      <= 1'b0;
         r_fetch_count <= 32'h0;
      end else begin
         r_state       <= w_state_next;
         r_pc          <= w_pc_next;
         r_halted      <= (w_state_next == StHalt);
         if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   if_id_reg_ #(
      .NOP_WORD (NOP_WORD)
   ) u_if_id_reg (
      .clk      (clk),
      .rst      (reset),
      .i_hold   (w_hold),
      .i_bubble (w_bubble),
      .i_load   (w_load),
      .i_pc4    (w_pc_inc),
      .i_instr  (imem_data),
      .o_pc4    (PC4D),
      .o_instr  (InstructionD),
      .o_valid  (validD)
   );

   assign imem_addr   = r_pc;
   assign halted      = r_halted;
   assign fetch_count = r_fetch_count;

endmodule
